// File: rtl/keypad_event_encoder_if.sv
// Keypad pin and key-event bundle between the keypad encoder (master) and
// its consumer (slave): matrix rows/columns plus the calculator key-event strobes.
interface keypad_event_encoder_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] num_val;
   logic [1:0] op_val;
   logic       is_num;
   logic       is_op;
   logic       is_eq;
   logic       is_clr;

   modport master (
      input  row_in,
      output col_out,
      output num_val,
      output op_val,
      output is_num,
      output is_op,
      output is_eq,
      output is_clr
   );

   modport slave (
      output row_in,
      input  col_out,
      input  num_val,
      input  op_val,
      input  is_num,
      input  is_op,
      input  is_eq,
      input  is_clr
   );
endinterface

// File: rtl/keypad_event_encoder.sv
// Scans a 4x4 active-low keypad, debounces whole-frame scan results and emits
// exactly one single-cycle key event per accepted press.
module keypad_event_encoder #(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 10
) (
   input logic                    clk,
   input logic                    rst,
   keypad_event_encoder_if.master kp
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_e;
   typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_e;
   typedef enum logic [1:0] {EV_NUM, EV_OP, EV_EQ, EV_CLR} ev_e;
   typedef struct packed {
      ev_e        kind;
      logic [3:0] val;
   } ev_t;

   // Key index is row*4 + column.
   function automatic ev_t decode_key(input logic [3:0] key);
      ev_t e;
      case (key)
         4'd0:    e = '{EV_NUM, 4'd1};
         4'd1:    e = '{EV_NUM, 4'd2};
         4'd2:    e = '{EV_NUM, 4'd3};
         4'd3:    e = '{EV_OP,  4'd0};
         4'd4:    e = '{EV_NUM, 4'd4};
         4'd5:    e = '{EV_NUM, 4'd5};
         4'd6:    e = '{EV_NUM, 4'd6};
         4'd7:    e = '{EV_OP,  4'd1};
         4'd8:    e = '{EV_NUM, 4'd7};
         4'd9:    e = '{EV_NUM, 4'd8};
         4'd10:   e = '{EV_NUM, 4'd9};
         4'd11:   e = '{EV_OP,  4'd2};
         4'd12:   e = '{EV_CLR, 4'd0};
         4'd13:   e = '{EV_NUM, 4'd0};
         4'd14:   e = '{EV_EQ,  4'd0};
         4'd15:   e = '{EV_OP,  4'd3};
         default: e = '{EV_NUM, 4'd0};
      endcase
      return e;
   endfunction

   logic [3:0]    row_meta_q, row_sync_q;
   logic [SW-1:0] slot_q;
   logic [1:0]    col_q;
   logic [3:0]    col_out_q;
   logic [3:0]    cap0_q, cap1_q, cap2_q;
   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    cand_q;
   logic [3:0]    num_val_q;
   logic [1:0]    op_val_q;
   logic          is_num_q, is_op_q, is_eq_q, is_clr_q;

   logic [15:0]   frame_rows_s;
   logic [4:0]    hits_s;
   logic [3:0]    key_s;
   frame_e        frame_s;
   logic          eval_s;
   logic          emit_s;
   logic [CW-1:0] cnt_inc_s;
   ev_t           ev_s;

   // Synchronizer, column scan and per-column row capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         slot_q     <= '0;
         col_q      <= 2'd0;
         col_out_q  <= 4'b1110;
         cap0_q     <= 4'hF;
         cap1_q     <= 4'hF;
         cap2_q     <= 4'hF;
      end else begin
         row_meta_q <= kp.row_in;
         row_sync_q <= row_meta_q;
         if (slot_q == SLOT_LAST) begin
            slot_q    <= '0;
            col_q     <= col_q + 2'd1;
            col_out_q <= {col_out_q[2:0], col_out_q[3]};
            case (col_q)
               2'd0:    cap0_q <= row_sync_q;
               2'd1:    cap1_q <= row_sync_q;
               2'd2:    cap2_q <= row_sync_q;
               default: cap0_q <= cap0_q;
            endcase
         end else begin
            slot_q <= slot_q + SW'(1);
         end
      end
   end

   // Column 3 is judged straight from the synchronizer on its own capture cycle.
   assign frame_rows_s = {row_sync_q, cap2_q, cap1_q, cap0_q};
   assign eval_s       = (slot_q == SLOT_LAST) && (col_q == 2'd3);
   assign cnt_inc_s    = cnt_q + CW'(1);
   assign ev_s         = decode_key(key_s);

   // Classify the frame as no key, one key, or several keys.
   always_comb begin
      hits_s = 5'd0;
      key_s  = 4'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (frame_rows_s[c*4 + r] == 1'b0) begin
               hits_s = hits_s + 5'd1;
               key_s  = 4'(r*4 + c);
            end else begin
               hits_s = hits_s;
            end
         end
      end
      if (hits_s == 5'd0) begin
         frame_s = FR_NONE;
      end else if (hits_s == 5'd1) begin
         frame_s = FR_KEY;
      end else begin
         frame_s = FR_MULTI;
      end
   end

   assign emit_s = eval_s && (frame_s == FR_KEY) &&
                   (((state_q == IDLE) && (DEBOUNCE == 1)) ||
                    ((state_q == PRESS_CHK) && (key_s == cand_q) && (cnt_inc_s == DEB_MAX)));

   // Debounce FSM, stepped once per completed frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= 4'hF;
      end else if (eval_s) begin
         case (state_q)
            IDLE: begin
               if (frame_s == FR_KEY) begin
                  cand_q  <= key_s;
                  cnt_q   <= (DEBOUNCE == 1) ? '0 : CW'(1);
                  state_q <= (DEBOUNCE == 1) ? HELD : PRESS_CHK;
               end else begin
                  state_q <= IDLE;
               end
            end
            PRESS_CHK: begin
               if (emit_s) begin
                  cnt_q   <= '0;
                  state_q <= HELD;
               end else if ((frame_s == FR_KEY) && (key_s == cand_q)) begin
                  cnt_q   <= cnt_inc_s;
               end else begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            HELD: begin
               if (frame_s == FR_NONE) begin
                  cnt_q   <= (DEBOUNCE == 1) ? '0 : CW'(1);
                  state_q <= (DEBOUNCE == 1) ? IDLE : RELEASE_CHK;
               end else begin
                  state_q <= HELD;
               end
            end
            RELEASE_CHK: begin
               if ((frame_s == FR_NONE) && (cnt_inc_s == DEB_MAX)) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (frame_s == FR_NONE) begin
                  cnt_q   <= cnt_inc_s;
               end else begin
                  cnt_q   <= '0;
                  state_q <= HELD;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end else begin
         state_q <= state_q;
      end
   end

   // Event strobes and value outputs; values hold between their own strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         num_val_q <= 4'd0;
         op_val_q  <= 2'd0;
         is_num_q  <= 1'b0;
         is_op_q   <= 1'b0;
         is_eq_q   <= 1'b0;
         is_clr_q  <= 1'b0;
      end else begin
         is_num_q <= 1'b0;
         is_op_q  <= 1'b0;
         is_eq_q  <= 1'b0;
         is_clr_q <= 1'b0;
         if (emit_s) begin
            case (ev_s.kind)
               EV_NUM: begin
                  is_num_q  <= 1'b1;
                  num_val_q <= ev_s.val;
               end
               EV_OP: begin
                  is_op_q  <= 1'b1;
                  op_val_q <= ev_s.val[1:0];
               end
               EV_EQ:   is_eq_q  <= 1'b1;
               EV_CLR:  is_clr_q <= 1'b1;
               default: is_num_q <= 1'b0;
            endcase
         end else begin
            num_val_q <= num_val_q;
         end
      end
   end

   assign kp.col_out = col_out_q;
   assign kp.num_val = num_val_q;
   assign kp.op_val  = op_val_q;
   assign kp.is_num  = is_num_q;
   assign kp.is_op   = is_op_q;
   assign kp.is_eq   = is_eq_q;
   assign kp.is_clr  = is_clr_q;
endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames)
// driving a keypad matrix model and checking event strobes, values and timing.
module tb_keypad_event_encoder;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 16;

   localparam int EV_NONE = 0;
   localparam int EV_NUM  = 1;
   localparam int EV_OP   = 2;
   localparam int EV_EQ   = 3;
   localparam int EV_CLR  = 4;

   // Key index = row*4 + column
   localparam int K_1 = 0,  K_2 = 1,  K_3 = 2,  K_PLUS = 3;
   localparam int K_5 = 5,  K_6 = 6;
   localparam int K_7 = 8,  K_9 = 10, K_MUL = 11;
   localparam int K_C = 12, K_0 = 13, K_EQ = 14, K_DIV = 15;

   typedef struct {
      string       name;
      logic [15:0] keys;
      int          frames;
      int          kind;
      int          val;
      int          at;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  row_model;
   int          checks = 0;
   int          errors = 0;
   int          exp_num = 0;
   int          exp_op = 0;
   vec_t        vecs[$];

   keypad_event_encoder_if kp ();

   keypad_event_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_model = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !kp.col_out[c]) row_model[r] = 1'b0;
         end
      end
   end
   assign kp.row_in = row_model;

   function automatic logic [15:0] mk(input int k);
      logic [15:0] one;
      one = 16'h0001;
      return one << k;
   endfunction

   function automatic vec_t mkv(input string n, input logic [15:0] k, input int f,
                                input int kind, input int val, input int at);
      vec_t v;
      v.name = n; v.keys = k; v.frames = f; v.kind = kind; v.val = val; v.at = at;
      return v;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int strobe_sum();
      return int'(kp.is_num) + int'(kp.is_op) + int'(kp.is_eq) + int'(kp.is_clr);
   endfunction

   // Hold a key set for whole frames, sampling each cycle just after the edge.
   task automatic run_step(input string name, input logic [15:0] k, input int frames,
                           input int kind, input int val, input int at);
      int n_strobe;
      int got_kind;
      int got_val;
      int got_at;
      int hot;
      n_strobe = 0; got_kind = EV_NONE; got_val = -1; got_at = -1;
      keys = k;
      for (int i = 1; i <= frames*FRAME; i++) begin
         @(posedge clk); #1;
         hot = strobe_sum();
         if (hot != 0) begin
            check($sformatf("%s_onehot", name), hot, 1);
            n_strobe++;
            got_at = i;
            if (kp.is_num) begin
               got_kind = EV_NUM; got_val = int'(kp.num_val);
            end else if (kp.is_op) begin
               got_kind = EV_OP;  got_val = int'(kp.op_val);
            end else if (kp.is_eq) begin
               got_kind = EV_EQ;
            end else begin
               got_kind = EV_CLR;
            end
         end
      end
      check($sformatf("%s_count", name), n_strobe, (kind != EV_NONE) ? 1 : 0);
      if (kind != EV_NONE) begin
         check($sformatf("%s_kind", name), got_kind, kind);
         check($sformatf("%s_cycle", name), got_at, at);
         if (kind == EV_NUM) begin
            check($sformatf("%s_val", name), got_val, val);
            exp_num = val;
         end else if (kind == EV_OP) begin
            check($sformatf("%s_val", name), got_val, val);
            exp_op = val;
         end
      end
      check($sformatf("%s_num_hold", name), int'(kp.num_val), exp_num);
      check($sformatf("%s_op_hold", name), int'(kp.op_val), exp_op);
   endtask

   initial begin
      int pre;
      vecs.push_back(mkv("press_7",      mk(K_7),            5, EV_NUM,  7, 48));
      vecs.push_back(mkv("rel_7",        16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_div",    mk(K_DIV),          4, EV_OP,   3, 48));
      vecs.push_back(mkv("rel_div",      16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_plus",   mk(K_PLUS),         4, EV_OP,   0, 48));
      vecs.push_back(mkv("short_rel",    16'h0000,           2, EV_NONE, 0, 0));
      vecs.push_back(mkv("repress_plus", mk(K_PLUS),         4, EV_NONE, 0, 0));
      vecs.push_back(mkv("rel_plus",     16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("bounce_5a",    mk(K_5),            2, EV_NONE, 0, 0));
      vecs.push_back(mkv("bounce_gap",   16'h0000,           1, EV_NONE, 0, 0));
      vecs.push_back(mkv("bounce_5b",    mk(K_5),            3, EV_NUM,  5, 48));
      vecs.push_back(mkv("rel_5",        16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("multi_12",     mk(K_1) | mk(K_2),  5, EV_NONE, 0, 0));
      vecs.push_back(mkv("single_1",     mk(K_1),            3, EV_NUM,  1, 48));
      vecs.push_back(mkv("rel_1",        16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_eq",     mk(K_EQ),           3, EV_EQ,   0, 48));
      vecs.push_back(mkv("rel_eq",       16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_clr",    mk(K_C),            3, EV_CLR,  0, 48));
      vecs.push_back(mkv("rel_clr",      16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_0",      mk(K_0),            3, EV_NUM,  0, 48));
      vecs.push_back(mkv("rel_0",        16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_mul",    mk(K_MUL),          3, EV_OP,   2, 48));
      vecs.push_back(mkv("rel_mul",      16'h0000,           3, EV_NONE, 0, 0));
      vecs.push_back(mkv("press_3",      mk(K_3),            3, EV_NUM,  3, 48));
      vecs.push_back(mkv("second_6",     mk(K_3) | mk(K_6),  2, EV_NONE, 0, 0));
      vecs.push_back(mkv("rel_36",       16'h0000,           3, EV_NONE, 0, 0));

      rst  = 1'b1;
      keys = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_col_out", int'(kp.col_out), 14);
      check("reset_num_val", int'(kp.num_val), 0);
      check("reset_op_val", int'(kp.op_val), 0);
      check("reset_strobes", strobe_sum(), 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_step(vecs[i].name, vecs[i].keys, vecs[i].frames,
                  vecs[i].kind, vecs[i].val, vecs[i].at);
      end

      // Reset while '9' is part-way through press debouncing.
      keys = mk(K_9);
      pre  = 0;
      for (int i = 1; i <= 36; i++) begin
         @(posedge clk); #1;
         pre += strobe_sum();
      end
      check("rst9_pre_strobes", pre, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst9_col_out", int'(kp.col_out), 14);
      check("rst9_strobes", strobe_sum(), 0);
      check("rst9_num_val", int'(kp.num_val), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_num = 0;
      exp_op  = 0;
      run_step("rst9_after", mk(K_9), 3, EV_NUM, 9, 48);
      run_step("rst9_rel", 16'h0000, 3, EV_NONE, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
